// File: rtl/chunked_adder_seq.sv
// chunked_adder_seq: TOTAL_W-bit adder built from a single CHUNK_W-bit slice.
// The slice is reused once per cycle, LSB chunk first, and the carry between
// chunks is kept in a register. Valid/ready handshakes on both sides; one
// operation is in flight at a time (accept, NCHUNK RUN cycles, present).
// Optional feature macro: CHUNK_ADD_SUB_EN (adds A-B support through the sub port).
module chunked_adder_seq #(
  parameter int TOTAL_W = 100,
  parameter int CHUNK_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] a,
  input  logic [TOTAL_W-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] sum,
  output logic               cout,
  output logic               busy
);

  localparam int NCHUNK = TOTAL_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Reject slice widths that do not tile the operand exactly.
  generate
    if (CHUNK_W < 1 || (TOTAL_W % CHUNK_W) != 0) begin : g_bad_chunk_w
      $error("chunked_adder_seq: TOTAL_W must be a multiple of CHUNK_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [TOTAL_W-1:0]   a_q;
  logic [TOTAL_W-1:0]   b_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 carry_q;
  logic [TOTAL_W-1:0]   acc_q;
  logic [TOTAL_W-1:0]   acc_d;
  logic [TOTAL_W-1:0]   sum_q;
  logic                 cout_q;

  logic [31:0]          chunk_base;
  logic [CHUNK_W-1:0]   a_chunk;
  logic [CHUNK_W-1:0]   b_chunk;
  logic [CHUNK_W:0]     chunk_sum;
  logic                 carry_init;

  assign chunk_base = 32'(idx_q) * 32'(CHUNK_W);
  assign a_chunk    = a_q[chunk_base +: CHUNK_W];

`ifdef CHUNK_ADD_SUB_EN
  logic sub_q;

  // Subtract is A + ~B + 1; the forced carry-in replaces cin.
  assign b_chunk    = b_q[chunk_base +: CHUNK_W] ^ {CHUNK_W{sub_q}};
  assign carry_init = sub ? 1'b1 : cin;
`else
  logic unused_sub;

  assign unused_sub = sub;
  assign b_chunk    = b_q[chunk_base +: CHUNK_W];
  assign carry_init = cin;
`endif

  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_W{1'b0}}, carry_q};

  // Merge the slice result into the working accumulator at the current chunk.
  always_comb begin
    acc_d = acc_q;
    acc_d[chunk_base +: CHUNK_W] = chunk_sum[CHUNK_W-1:0];
  end

  // Sequencer: capture operands, ripple one chunk per cycle, hold result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CHUNK_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= carry_init;
            idx_q   <= '0;
            acc_q   <= '0;
`ifdef CHUNK_ADD_SUB_EN
            sub_q   <= sub;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= chunk_sum[CHUNK_W];
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            sum_q   <= acc_d;
            cout_q  <= chunk_sum[CHUNK_W];
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status decodes from the state register; in_ready is also held low while reset is asserted.
  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Directed bench for chunked_adder_seq: default 100/10 instance plus a
// single-chunk (CHUNK_W == TOTAL_W) instance.
module tb_chunked_adder_seq;

  localparam int TW = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] sum;
  logic          cout;
  logic          busy;

  logic          u_in_valid;
  logic          u_in_ready;
  logic [TW-1:0] u_a;
  logic [TW-1:0] u_b;
  logic          u_cin;
  logic          u_sub;
  logic          u_out_valid;
  logic          u_out_ready;
  logic [TW-1:0] u_sum;
  logic          u_cout;
  logic          u_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  chunked_adder_seq #(.TOTAL_W(TW), .CHUNK_W(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  chunked_adder_seq #(.TOTAL_W(TW), .CHUNK_W(TW)) dut_one (
    .clk(clk), .reset(reset), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .a(u_a), .b(u_b), .cin(u_cin), .sub(u_sub), .out_valid(u_out_valid),
    .out_ready(u_out_ready), .sum(u_sum), .cout(u_cout), .busy(u_busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] rand_op();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[TW-1:0];
  endfunction

  // Accept one operation, scramble the inputs, and wait for out_valid.
  task automatic run_op(input logic [TW-1:0] a_v, input logic [TW-1:0] b_v,
                        input logic cin_v, input logic sub_v,
                        output logic [TW:0] res, output int lat);
    int guard;
    a = a_v; b = b_v; cin = cin_v; sub = sub_v; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_timeout", 128'(guard < 20), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~a_v; b = a_v ^ b_v ^ rand_op(); cin = ~cin_v; sub = ~sub_v;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("run_ready_busy", 128'({in_ready, busy}), 128'(2'b01));
      @(posedge clk); #1; lat++;
    end
    check("done_timeout", 128'(lat < 40), 128'(1));
    check("done_flags", 128'({in_ready, busy, out_valid}), 128'(3'b011));
    res = {cout, sum};
  endtask

  // Output handshake with out_ready already high; block must be idle right after.
  task automatic finish_op();
    @(posedge clk); #1;
    check("post_hs_flags", 128'({in_ready, busy, out_valid}), 128'(3'b100));
  endtask

  initial begin
    logic [TW:0]   res;
    logic [TW:0]   exp_v;
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic [TW-1:0] hb;
    logic [TW-1:0] ones;
    logic          rc;
    int            lat;
    int            g;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    u_in_valid = 1'b0; u_a = '0; u_b = '0; u_cin = 1'b0; u_sub = 1'b0; u_out_ready = 1'b1;
    ones = '1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", 128'({in_ready, busy, out_valid}), 128'(3'b000));
    check("rst_sum", 128'({cout, sum}), 128'(0));
    reset = 1'b0;
    #1;
    check("rst_release_ready", 128'(in_ready), 128'(1));

    // Full ripple: all ones + 0 + 1.
    run_op(ones, '0, 1'b1, 1'b0, res, lat);
    check("ripple_result", 128'(res), 128'({1'b1, {TW{1'b0}}}));
    check("ripple_latency", 128'(lat), 128'(10));
    finish_op();

    // Directed small and boundary vectors.
    run_op(TW'(3), TW'(4), 1'b0, 1'b0, res, lat);
    check("small_add", 128'(res), 128'(7));
    finish_op();
    run_op(TW'(1023), TW'(1), 1'b0, 1'b0, res, lat);
    check("chunk_carry", 128'(res), 128'(1024));
    finish_op();
    run_op(ones, ones, 1'b1, 1'b0, res, lat);
    check("max_add", 128'(res), 128'({1'b1, ones}));
    finish_op();

    // Random back-to-back operations.
    for (int i = 0; i < 200; i++) begin
      ra = rand_op(); rb = rand_op(); rc = 1'($urandom_range(0, 1));
      exp_v = {1'b0, ra} + {1'b0, rb} + {{TW{1'b0}}, rc};
      run_op(ra, rb, rc, 1'b0, res, lat);
      check("rand_result", 128'(res), 128'(exp_v));
      check("rand_latency", 128'(lat), 128'(10));
      finish_op();
    end

    // Back-pressure in DONE while new operands are offered.
    out_ready = 1'b0;
    run_op(TW'(100), TW'(23), 1'b1, 1'b0, res, lat);
    check("bp_result", 128'(res), 128'(124));
    for (int i = 0; i < 5; i++) begin
      a = rand_op(); b = rand_op(); in_valid = 1'(i % 2 == 0); out_ready = 1'b0;
      @(posedge clk); #1;
      check("bp_hold", 128'({cout, sum}), 128'(124));
      check("bp_flags", 128'({in_ready, busy, out_valid}), 128'(3'b011));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 128'({in_ready, busy, out_valid}), 128'(3'b100));
    check("bp_sum_kept", 128'({cout, sum}), 128'(124));

    // Reset mid-RUN at chunk index 4 discards the operation.
    a = ones; b = ones; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_abort_busy", 128'({busy, out_valid}), 128'(2'b10));
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_flags", 128'({in_ready, busy, out_valid}), 128'(3'b000));
    check("abort_sum", 128'({cout, sum}), 128'(0));
    reset = 1'b0;
    #1;
    check("abort_ready", 128'(in_ready), 128'(1));
    g = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) g++;
    end
    check("abort_no_output", 128'(g), 128'(0));
    run_op(TW'(3), TW'(4), 1'b0, 1'b0, res, lat);
    check("after_abort", 128'(res), 128'(7));
    finish_op();

    // Subtract request.
`ifdef CHUNK_ADD_SUB_EN
    run_op(TW'(5), TW'(7), 1'b0, 1'b1, res, lat);
    check("sub_borrow", 128'(res), 128'({1'b0, ones - TW'(1)}));
    finish_op();
    run_op(TW'(7), TW'(5), 1'b0, 1'b1, res, lat);
    check("sub_no_borrow", 128'(res), 128'({1'b1, TW'(2)}));
    finish_op();
`else
    run_op(TW'(5), TW'(7), 1'b0, 1'b1, res, lat);
    check("sub_ignored", 128'(res), 128'(12));
    finish_op();
`endif

    // Single-chunk instance: 2^99 + 2^99 and exactly one RUN cycle.
    hb = '0; hb[TW-1] = 1'b1;
    u_a = hb; u_b = hb; u_cin = 1'b0; u_in_valid = 1'b1;
    check("one_ready", 128'(u_in_ready), 128'(1));
    @(posedge clk); #1;
    u_in_valid = 1'b0; u_a = '0; u_b = '0;
    check("one_run", 128'({u_in_ready, u_busy, u_out_valid}), 128'(3'b010));
    @(posedge clk); #1;
    check("one_done", 128'({u_in_ready, u_busy, u_out_valid}), 128'(3'b011));
    check("one_result", 128'({u_cout, u_sum}), 128'({1'b1, {TW{1'b0}}}));
    @(posedge clk); #1;
    check("one_idle", 128'({u_in_ready, u_busy, u_out_valid}), 128'(3'b100));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
